dps_enc_27: RTL and testbench

Sequential encoder that converts a binary data word into the 27-bit Fibonacci-numeral-system (FNS) codeword used on the crosstalk-avoidance link. It sits directly upstream of `DPS_dec_27`, and its codeword must decode back to the original data through that block. Encoding is greedy and MSB-first, one code bit per cycle, with valid/ready handshakes on both sides.

---
 rtl/dps_enc_27_pkg.sv | 24 ++
 rtl/dps_enc_27_weight_rom.sv | 45 ++++
 rtl/dps_enc_27.sv | 90 +++++++++
 tb/tb_dps_enc_27.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/dps_enc_27_pkg.sv
// rtl/dps_enc_27_pkg.sv - FNS weight constants, data width and encoder state type
package dps_enc_27_pkg;

  localparam int unsigned FNS01 = 1,     FNS02 = 1,     FNS03 = 2,     FNS04 = 3;
  localparam int unsigned FNS05 = 5,     FNS06 = 8,     FNS07 = 13,    FNS08 = 21;
  localparam int unsigned FNS09 = 34,    FNS10 = 55,    FNS11 = 89,    FNS12 = 144;
  localparam int unsigned FNS13 = 233,   FNS14 = 377,   FNS15 = 610,   FNS16 = 987;
  localparam int unsigned FNS17 = 1597,  FNS18 = 2584,  FNS19 = 4181,  FNS20 = 6765;
  localparam int unsigned FNS21 = 10946, FNS22 = 17711, FNS23 = 28657, FNS24 = 46368;
  localparam int unsigned FNS25 = 75025, FNS26 = 121393, FNS27 = 196418;

  // Bit 25 carries a doubled weight; shared with the decoder side.
  localparam int unsigned FNSW25 = 2 * FNS26;

  // Sum of all weights is 635621, which fits in 20 bits.
  localparam int DBLEN27 = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } enc_state_t;

endpackage

// File: rtl/dps_enc_27_weight_rom.sv
// rtl/dps_enc_27_weight_rom.sv - combinational 27-entry FNS weight table
module fns_weight_rom_27
  import dps_enc_27_pkg::*;
#(
  parameter int DW = DBLEN27
) (
  input  logic [4:0]    idx,
  output logic [DW-1:0] weight
);

  always_comb begin
    weight = '0;
    case (idx)
      5'd0:  weight = DW'(FNS01);
      5'd1:  weight = DW'(FNS02);
      5'd2:  weight = DW'(FNS03);
      5'd3:  weight = DW'(FNS04);
      5'd4:  weight = DW'(FNS05);
      5'd5:  weight = DW'(FNS06);
      5'd6:  weight = DW'(FNS07);
      5'd7:  weight = DW'(FNS08);
      5'd8:  weight = DW'(FNS09);
      5'd9:  weight = DW'(FNS10);
      5'd10: weight = DW'(FNS11);
      5'd11: weight = DW'(FNS12);
      5'd12: weight = DW'(FNS13);
      5'd13: weight = DW'(FNS14);
      5'd14: weight = DW'(FNS15);
      5'd15: weight = DW'(FNS16);
      5'd16: weight = DW'(FNS17);
      5'd17: weight = DW'(FNS18);
      5'd18: weight = DW'(FNS19);
      5'd19: weight = DW'(FNS20);
      5'd20: weight = DW'(FNS21);
      5'd21: weight = DW'(FNS22);
      5'd22: weight = DW'(FNS23);
      5'd23: weight = DW'(FNS24);
      5'd24: weight = DW'(FNS25);
      5'd25: weight = DW'(FNSW25);
      5'd26: weight = DW'(FNS27);
      default: weight = '0;
    endcase
  end

endmodule

// File: rtl/dps_enc_27.sv
// rtl/dps_enc_27.sv - greedy MSB-first FNS encoder, one code bit per cycle
module dps_enc_27
  import dps_enc_27_pkg::*;
#(
  parameter int DW = DBLEN27
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] datain,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [26:0]   codeout,
  output logic          err
);

  enc_state_t    state, state_n;
  logic [4:0]    idx, idx_n;
  logic [DW-1:0] rem, rem_n;
  logic [26:0]   code, code_n;
  logic [26:0]   codeout_n;
  logic          err_n;
  logic [DW-1:0] weight;

  fns_weight_rom_27 #(.DW(DW)) u_rom (
    .idx    (idx),
    .weight (weight)
  );

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    rem_n     = rem;
    code_n    = code;
    codeout_n = codeout;
    err_n     = err;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          rem_n   = datain;
          idx_n   = 5'd26;
          code_n  = '0;
          state_n = RUN;
        end
      end
      RUN: begin
        if (rem >= weight) begin
          code_n = code | (27'd1 << idx);
          rem_n  = rem - weight;
        end
        // Publish the result on the last bit so outputs are registered on entry to DONE.
        if (idx == 5'd0) begin
          state_n   = DONE;
          codeout_n = code_n;
          err_n     = (rem_n != '0);
        end else begin
          idx_n = idx - 5'd1;
        end
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      rem       <= '0;
      code      <= '0;
      codeout   <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      rem       <= rem_n;
      code      <= code_n;
      codeout   <= codeout_n;
      err       <= err_n;
      out_valid <= (state_n == DONE);
      in_ready  <= (state_n == IDLE);
    end
  end

endmodule

// File: tb/tb_dps_enc_27.sv
// tb/tb_dps_enc_27.sv - scoreboard bench for dps_enc_27 with a reference FNS decoder
module tb_dps_enc_27;

  localparam int DW = 20;
  localparam int MAXSUM = 635621;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] datain = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [26:0]   codeout;
  logic          err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic [26:0]   code;
    bit            chk_code;
    bit            exp_err;
    bit            chk_err;
  } exp_t;

  exp_t sb[$];
  longint unsigned w[27];

  dps_enc_27 #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .datain    (datain),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .codeout   (codeout),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic longint unsigned decode(input logic [26:0] c);
    longint unsigned s = 0;
    for (int k = 0; k < 27; k++) if (c[k]) s += w[k];
    return s;
  endfunction

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [26:0] c, input bit chk_c,
                      input bit e, input bit chk_e);
    exp_t x;
    @(negedge clk);
    for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
    in_valid = 1'b1;
    datain   = d;
    @(posedge clk);
    x.data = d; x.code = c; x.chk_code = chk_c; x.exp_err = e; x.chk_err = chk_e;
    sb.push_back(x);
    #1;
    in_valid = 1'b0;
    datain   = DW'($urandom);
  endtask

  task automatic receive(input bit rnd_ready, output int lat);
    bit got = 0;
    exp_t x;
    longint unsigned dec;
    lat = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      lat++;
      out_ready = rnd_ready ? 1'($urandom_range(1, 0)) : 1'b1;
      if (out_valid && out_ready) begin
        got = 1;
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL sb_empty: observed output %0h with no pending word", codeout);
        end
        if (sb.size() != 0) begin
          x   = sb.pop_front();
          dec = decode(codeout);
          if (x.chk_code) check("codeout", codeout, x.code);
          if (x.chk_err) check("err", err, x.exp_err);
          check("err_vs_decode", err, (dec != x.data));
          if (!err) check("roundtrip", dec, x.data);
        end
      end
    end
    checks++;
    assert (got) else begin
      errors++;
      $error("FAIL timeout: observed no output, expected one within 400 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    bit seen;
    longint unsigned f[28];
    f[1] = 1; f[2] = 1;
    for (int k = 3; k < 28; k++) f[k] = f[k-1] + f[k-2];
    for (int k = 0; k < 25; k++) w[k] = f[k+1];
    w[25] = 2 * f[26];
    w[26] = f[27];

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_codeout", codeout, 0);
    check("rst_err", err, 0);
    rst = 1'b0;

    send(20'd0, 27'h0, 1, 0, 1);
    receive(0, lat);
    check("latency", lat, 28);
    @(negedge clk);
    check("in_ready_after_handoff", in_ready, 1);

    send(20'd1, 27'h0000002, 1, 0, 1);
    receive(0, lat);
    send(20'd3, 27'h0000008, 1, 0, 1);
    receive(0, lat);

    // Backpressure: DONE held for 10 cycles while upstream keeps offering data.
    out_ready = 1'b0;
    send(20'd4, 27'h000000A, 1, 0, 1);
    for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      datain   = 20'd99;
      check("bp_codeout", codeout, 27'h000000A);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    receive(0, lat);
    @(negedge clk);
    check("bp_idle_after", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("bp_no_extra_accept", seen, 0);

    // Reset in the middle of RUN discards the word.
    send(20'd7, 27'h0, 0, 0, 0);
    repeat (13) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_codeout", codeout, 0);
    check("abort_err", err, 0);
    rst = 1'b0;
    void'(sb.pop_front());
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("abort_no_output", seen, 0);

    send({DW{1'b1}}, 27'h0, 0, 1, 1);
    receive(0, lat);
    send(20'(MAXSUM), 27'h7FFFFFF, 1, 0, 1);
    receive(0, lat);

    for (int n = 0; n < 1500; n++) begin
      send(20'($urandom_range(MAXSUM, 0)), 27'h0, 0, 0, 0);
      receive(1, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
